// File: rtl/des_seq.sv
`default_nettype none
// ============================================================================
//  Module   : des_seq
//  Purpose  : Sequencer for the DES data register and round core. Gates bus
//             access to the two-word data register, launches the core once a
//             64-bit block is loaded, steps it through the rounds, writes the
//             result back and releases it for two bus reads.
//  Revision : 1.0  initial release
// ============================================================================
module des_seq #(
  parameter int ROUNDS = 16,
  parameter int CNT_W  = 4,
  parameter int LAT    = 1
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             ctrl_en,
  input  logic             abort,
  input  logic             decrypt,
  input  logic             bus_wr,
  input  logic             bus_rd,
  input  logic             full_pulse,
  output logic             wr_en,
  output logic             rd_en,
  output logic             clrptr,
  output logic             load_in,
  output logic             round_en,
  output logic [CNT_W-1:0] round,
  output logic             dec_mode,
  output logic             deswr,
  output logic             busy,
  output logic             done_irq
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_LOAD   = 3'd2,
    S_ROUND  = 3'd3,
    S_FLUSH  = 3'd4,
    S_WRBK   = 3'd5,
    S_RESULT = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] c_round_last = CNT_W'(ROUNDS - 1);
  // FLUSH is unreachable when LAT is 0, so the terminal value is irrelevant then
  localparam logic [1:0]       c_flush_last = (LAT > 0) ? 2'(LAT - 1) : 2'd0;

  state_t           r_state,     w_state_nxt;
  logic [CNT_W-1:0] r_round,     w_round_nxt;
  logic             r_dec,       w_dec_nxt;
  logic             r_rd_cnt,    w_rd_cnt_nxt;
  logic [1:0]       r_flush_cnt, w_flush_cnt_nxt;
  logic             w_kill;

  // Abort or disable pre-empts everything except reset
  assign w_kill   = abort | ~ctrl_en;
  assign round    = r_round;
  assign dec_mode = r_dec;

  // State and counter registers
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state     <= S_IDLE;
      r_round     <= '0;
      r_dec       <= 1'b0;
      r_rd_cnt    <= 1'b0;
      r_flush_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_round     <= w_round_nxt;
      r_dec       <= w_dec_nxt;
      r_rd_cnt    <= w_rd_cnt_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // Next-state, counter updates and output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_round_nxt     = r_round;
    w_dec_nxt       = r_dec;
    w_rd_cnt_nxt    = r_rd_cnt;
    w_flush_cnt_nxt = r_flush_cnt;
    wr_en           = 1'b0;
    rd_en           = 1'b0;
    load_in         = 1'b0;
    round_en        = 1'b0;
    deswr           = 1'b0;
    done_irq        = 1'b0;
    // The single IDLE cycle per block doubles as the register pointer clear
    clrptr          = (r_state != S_IDLE);
    busy            = (r_state == S_LOAD) || (r_state == S_ROUND) ||
                      (r_state == S_FLUSH) || (r_state == S_WRBK);

    case (r_state)
      S_IDLE: begin
        w_state_nxt     = S_FILL;
        w_round_nxt     = '0;
        w_rd_cnt_nxt    = 1'b0;
        w_flush_cnt_nxt = 2'd0;
      end
      S_FILL: begin
        wr_en = bus_wr;
        if (full_pulse) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        load_in     = 1'b1;
        w_dec_nxt   = decrypt;
        w_round_nxt = '0;
        w_state_nxt = S_ROUND;
      end
      S_ROUND: begin
        round_en = 1'b1;
        // round parks on the last index so the strobe count is exactly ROUNDS
        if (r_round == c_round_last) begin
          w_flush_cnt_nxt = 2'd0;
          w_state_nxt     = (LAT > 0) ? S_FLUSH : S_WRBK;
        end else begin
          w_round_nxt = r_round + 1'b1;
        end
      end
      S_FLUSH: begin
        if (r_flush_cnt == c_flush_last) begin
          w_state_nxt = S_WRBK;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt + 2'd1;
        end
      end
      S_WRBK: begin
        deswr        = 1'b1;
        done_irq     = 1'b1;
        w_rd_cnt_nxt = 1'b0;
        w_state_nxt  = S_RESULT;
      end
      S_RESULT: begin
        rd_en = bus_rd;
        if (bus_rd) begin
          if (r_rd_cnt) begin
            w_state_nxt  = S_IDLE;
            w_round_nxt  = '0;
            w_rd_cnt_nxt = 1'b0;
          end else begin
            w_rd_cnt_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort/disable: squash all strobes this cycle, keep the latched mode
    if (w_kill) begin
      w_state_nxt     = S_IDLE;
      w_round_nxt     = '0;
      w_rd_cnt_nxt    = 1'b0;
      w_flush_cnt_nxt = 2'd0;
      w_dec_nxt       = r_dec;
      wr_en           = 1'b0;
      rd_en           = 1'b0;
      load_in         = 1'b0;
      round_en        = 1'b0;
      deswr           = 1'b0;
      done_irq        = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_des_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_des_seq
//  Purpose  : Self-checking bench for des_seq (default and short parameters)
//  Revision : 1.0  initial release
// ============================================================================
module tb_des_seq;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  logic ctrl_en = 1'b0, abort = 1'b0, decrypt = 1'b0;
  logic bus_wr = 1'b0, bus_rd = 1'b0, full_pulse = 1'b0;
  logic ctrl_en2 = 1'b0, full_pulse2 = 1'b0;

  logic       wr_en, rd_en, clrptr, load_in, round_en, dec_mode, deswr, busy, done_irq;
  logic [3:0] round;
  logic       wr_en2, rd_en2, clrptr2, load_in2, round_en2, dec_mode2, deswr2, busy2, done_irq2;
  logic [1:0] round2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 hclk = ~hclk;

  des_seq #(.ROUNDS(16), .CNT_W(4), .LAT(1)) dut (
    .hclk(hclk), .hresetn(hresetn), .ctrl_en(ctrl_en), .abort(abort),
    .decrypt(decrypt), .bus_wr(bus_wr), .bus_rd(bus_rd), .full_pulse(full_pulse),
    .wr_en(wr_en), .rd_en(rd_en), .clrptr(clrptr), .load_in(load_in),
    .round_en(round_en), .round(round), .dec_mode(dec_mode), .deswr(deswr),
    .busy(busy), .done_irq(done_irq)
  );

  des_seq #(.ROUNDS(2), .CNT_W(2), .LAT(0)) dut2 (
    .hclk(hclk), .hresetn(hresetn), .ctrl_en(ctrl_en2), .abort(abort),
    .decrypt(decrypt), .bus_wr(bus_wr), .bus_rd(bus_rd), .full_pulse(full_pulse2),
    .wr_en(wr_en2), .rd_en(rd_en2), .clrptr(clrptr2), .load_in(load_in2),
    .round_en(round_en2), .round(round2), .dec_mode(dec_mode2), .deswr(deswr2),
    .busy(busy2), .done_irq(done_irq2)
  );

  // {wr, rd, clr, ld, ren, round[3:0], dm, dw, busy, irq}
  logic [12:0] w_out;
  assign w_out = {wr_en, rd_en, clrptr, load_in, round_en, round,
                  dec_mode, deswr, busy, done_irq};

  typedef struct packed {
    logic [5:0]  in;   // {ctrl_en, abort, decrypt, bus_wr, bus_rd, full_pulse}
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [5:0] fin(logic ce, logic ab, logic dc, logic bw, logic br, logic fp);
    return {ce, ab, dc, bw, br, fp};
  endfunction

  function automatic logic [12:0] fex(logic wr, logic rd, logic clr, logic ld, logic ren,
                                      logic [3:0] rnd, logic dm, logic dw, logic bsy, logic irq);
    return {wr, rd, clr, ld, ren, rnd, dm, dw, bsy, irq};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One complete block on either instance; optionally reset after the first read
  task automatic run_block(input bit sel, input int nr, input int lat, input bit do_rst);
    int k;
    int nren;
    bit got;
    if (sel) ctrl_en2 = 1'b1; else ctrl_en = 1'b1;
    decrypt = 1'b0;
    @(negedge hclk); bus_wr = 1'b1;
    @(negedge hclk); bus_wr = 1'b1;
    @(negedge hclk); bus_wr = 1'b0;
    if (sel) full_pulse2 = 1'b1; else full_pulse = 1'b1;
    @(negedge hclk); full_pulse = 1'b0; full_pulse2 = 1'b0;
    #1 check($sformatf("blk%0d_load", sel), sel ? load_in2 : load_in, 1);
    k = 0; nren = 0; got = 1'b0;
    while (!got && k < 60) begin
      @(negedge hclk); #1;
      k++;
      if (sel ? round_en2 : round_en) nren++;
      if (sel ? deswr2 : deswr) begin
        got = 1'b1;
        check($sformatf("blk%0d_irq", sel), sel ? done_irq2 : done_irq, 1);
      end
    end
    check($sformatf("blk%0d_latency", sel), k, 1 + nr + lat);
    check($sformatf("blk%0d_nrounds", sel), nren, nr);
    @(negedge hclk); bus_rd = 1'b1;
    #1 check($sformatf("blk%0d_rd1", sel), sel ? rd_en2 : rd_en, 1);
    if (do_rst) begin
      #2 hresetn = 1'b0; ctrl_en = 1'b0; bus_rd = 1'b0;
      #1 check("async_rst_outputs", {19'd0, w_out}, 32'd0);
      @(negedge hclk); hresetn = 1'b1;
      #1 check("post_rst_idle", {19'd0, w_out}, 32'd0);
    end else begin
      @(negedge hclk); bus_rd = 1'b1;
      #1 check($sformatf("blk%0d_rd2", sel), sel ? rd_en2 : rd_en, 1);
      @(negedge hclk); bus_rd = 1'b0; ctrl_en = 1'b0; ctrl_en2 = 1'b0;
      #1 check($sformatf("blk%0d_clrptr", sel), sel ? clrptr2 : clrptr, 0);
      @(negedge hclk);
    end
  endtask

  initial begin
    // Block 1: full encrypt-or-decrypt run with gating checks
    tbl.push_back('{fin(0,0,0,0,0,0), fex(0,0,0,0,0,4'd0,0,0,0,0)});
    tbl.push_back('{fin(1,0,0,0,0,0), fex(0,0,0,0,0,4'd0,0,0,0,0)});
    tbl.push_back('{fin(1,0,0,1,0,0), fex(1,0,1,0,0,4'd0,0,0,0,0)});
    tbl.push_back('{fin(1,0,0,1,0,0), fex(1,0,1,0,0,4'd0,0,0,0,0)});
    tbl.push_back('{fin(1,0,0,0,1,0), fex(0,0,1,0,0,4'd0,0,0,0,0)});
    tbl.push_back('{fin(1,0,0,0,0,1), fex(0,0,1,0,0,4'd0,0,0,0,0)});
    tbl.push_back('{fin(1,0,1,0,0,0), fex(0,0,1,1,0,4'd0,0,0,1,0)});
    for (int i = 0; i < 16; i++) begin
      tbl.push_back('{fin(1,0,i[0],1,0,(i == 3)), fex(0,0,1,0,1,4'(i),1,0,1,0)});
    end
    tbl.push_back('{fin(1,0,0,0,0,0), fex(0,0,1,0,0,4'd15,1,0,1,0)});
    tbl.push_back('{fin(1,0,0,0,0,0), fex(0,0,1,0,0,4'd15,1,1,1,1)});
    tbl.push_back('{fin(1,0,0,1,0,0), fex(0,0,1,0,0,4'd15,1,0,0,0)});
    tbl.push_back('{fin(1,0,0,0,1,0), fex(0,1,1,0,0,4'd15,1,0,0,0)});
    tbl.push_back('{fin(1,0,0,0,0,0), fex(0,0,1,0,0,4'd15,1,0,0,0)});
    tbl.push_back('{fin(1,0,0,0,1,0), fex(0,1,1,0,0,4'd15,1,0,0,0)});
    tbl.push_back('{fin(1,0,0,0,0,0), fex(0,0,0,0,0,4'd0,1,0,0,0)});
    // Block 2: third write passes, decrypt=0 latched, abort at round 7
    tbl.push_back('{fin(1,0,0,1,0,0), fex(1,0,1,0,0,4'd0,1,0,0,0)});
    tbl.push_back('{fin(1,0,0,1,0,0), fex(1,0,1,0,0,4'd0,1,0,0,0)});
    tbl.push_back('{fin(1,0,0,1,0,0), fex(1,0,1,0,0,4'd0,1,0,0,0)});
    tbl.push_back('{fin(1,0,0,0,0,1), fex(0,0,1,0,0,4'd0,1,0,0,0)});
    tbl.push_back('{fin(1,0,0,0,0,0), fex(0,0,1,1,0,4'd0,1,0,1,0)});
    for (int i = 0; i < 7; i++) begin
      tbl.push_back('{fin(1,0,1,0,0,0), fex(0,0,1,0,1,4'(i),0,0,1,0)});
    end
    tbl.push_back('{fin(1,1,1,0,1,0), fex(0,0,1,0,0,4'd7,0,0,1,0)});
    tbl.push_back('{fin(1,0,0,0,0,0), fex(0,0,0,0,0,4'd0,0,0,0,0)});
    // ctrl_en low in FILL squashes the write and returns to IDLE
    tbl.push_back('{fin(0,0,0,1,0,0), fex(0,0,1,0,0,4'd0,0,0,0,0)});
    tbl.push_back('{fin(0,0,0,0,0,0), fex(0,0,0,0,0,4'd0,0,0,0,0)});

    // Reset state
    #12;
    check("reset_outputs", {19'd0, w_out}, 32'd0);
    check("reset_outputs_dut2", {25'd0, wr_en2, rd_en2, clrptr2, load_in2, round_en2,
                                 round2, dec_mode2, deswr2}, 32'd0);
    @(negedge hclk); hresetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge hclk);
      {ctrl_en, abort, decrypt, bus_wr, bus_rd, full_pulse} = tbl[i].in;
      #1 check($sformatf("vec[%0d]", i), {19'd0, w_out}, {19'd0, tbl[i].exp});
    end
    @(negedge hclk);
    {ctrl_en, abort, decrypt, bus_wr, bus_rd, full_pulse} = 6'd0;

    // Async reset in RESULT after one read, then a clean block
    run_block(1'b0, 16, 1, 1'b1);
    run_block(1'b0, 16, 1, 1'b0);
    // Short-parameter instance: 2 rounds, no flush
    run_block(1'b1, 2, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
